// File: rtl/alu_pkg.sv
// Shared constants for the arithmetic_logical_unit: data/opcode widths and opcode values.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;
    localparam int FLAG_W = 4;

    localparam logic [OP_W-1:0] OP_ADD    = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB    = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL    = 4'd2;
    localparam logic [OP_W-1:0] OP_LOGIC1 = 4'd3;
    localparam logic [OP_W-1:0] OP_LOGIC2 = 4'd4;
    localparam logic [OP_W-1:0] OP_SHIFT  = 4'd5;
    localparam logic [OP_W-1:0] OP_DIV    = 4'd6;

endpackage

// File: rtl/alu_divider.sv
// Combinational 8/8 unsigned restoring divider; divide-by-zero yields quotient 8'hFF, remainder = dividend.
import alu_pkg::*;

module alu_divider (
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [DATA_W:0]   partial;
    logic [DATA_W-1:0] q_raw;

    // One restoring stage per quotient bit, MSB first; partial stays below divisor so 9 bits suffice.
    always_comb begin
        partial = '0;
        q_raw   = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            partial = {partial[DATA_W-1:0], dividend[i]};
            if (partial >= {1'b0, divisor}) begin
                partial  = partial - {1'b0, divisor};
                q_raw[i] = 1'b1;
            end
        end
    end

    always_comb begin
        quotient  = q_raw;
        remainder = partial[DATA_W-1:0];
        if (divisor == '0) begin
            quotient  = '1;
            remainder = dividend;
        end
    end

endmodule

// File: rtl/arithmetic_logical_unit.sv
// Two-result 8-bit ALU with registered outputs, one-cycle latency, no handshake (every cycle is a new op).
// Optional macro ALU_FLAGS_EN adds the registered {div_by_zero, overflow, carry, zero} flags port.
import alu_pkg::*;

module arithmetic_logical_unit (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] operand_1,
    input  logic [DATA_W-1:0] operand_2,
    input  logic [OP_W-1:0]   operator,
`ifdef ALU_FLAGS_EN
    output logic [FLAG_W-1:0] flags,
`endif
    output logic [DATA_W-1:0] Answer1,
    output logic [DATA_W-1:0] Answer2
);

    logic [DATA_W:0]     add_ext;
    logic [DATA_W:0]     sub_ext;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   div_q;
    logic [DATA_W-1:0]   div_r;
    logic [DATA_W-1:0]   res1;
    logic [DATA_W-1:0]   res2;

    assign add_ext = {1'b0, operand_1} + {1'b0, operand_2};
    assign sub_ext = {1'b0, operand_1} - {1'b0, operand_2};
    assign product = {{DATA_W{1'b0}}, operand_1} * {{DATA_W{1'b0}}, operand_2};

    alu_divider u_divider (
        .dividend  (operand_1),
        .divisor   (operand_2),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_comb begin
        res1 = '0;
        res2 = '0;
        case (operator)
            OP_ADD:    begin res1 = add_ext[DATA_W-1:0]; res2 = {7'b0, add_ext[DATA_W]}; end
            OP_SUB:    begin res1 = sub_ext[DATA_W-1:0]; res2 = {7'b0, sub_ext[DATA_W]}; end
            OP_MUL:    begin res1 = product[DATA_W-1:0]; res2 = product[2*DATA_W-1:DATA_W]; end
            OP_LOGIC1: begin res1 = operand_1 & operand_2; res2 = operand_1 | operand_2; end
            OP_LOGIC2: begin res1 = operand_1 ^ operand_2; res2 = ~(operand_1 ^ operand_2); end
            OP_SHIFT:  begin res1 = operand_1 << operand_2[2:0]; res2 = operand_1 >> operand_2[2:0]; end
            OP_DIV:    begin res1 = div_q; res2 = div_r; end
            default:   begin res1 = '0; res2 = '0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Answer1 <= '0;
            Answer2 <= '0;
        end else begin
            Answer1 <= res1;
            Answer2 <= res2;
        end
    end

`ifdef ALU_FLAGS_EN
    logic [FLAG_W-1:0] flags_next;

    // Signed overflow: same-sign operands for add (opposite for sub) whose result sign flips.
    always_comb begin
        flags_next    = '0;
        flags_next[0] = (res1 == '0);
        flags_next[3] = (operator == OP_DIV) && (operand_2 == '0);
        case (operator)
            OP_ADD: begin
                flags_next[1] = add_ext[DATA_W];
                flags_next[2] = (operand_1[7] == operand_2[7]) && (add_ext[7] != operand_1[7]);
            end
            OP_SUB: begin
                flags_next[1] = sub_ext[DATA_W];
                flags_next[2] = (operand_1[7] != operand_2[7]) && (sub_ext[7] != operand_1[7]);
            end
            OP_MUL:  flags_next[1] = (product[2*DATA_W-1:DATA_W] != '0);
            default: flags_next[1] = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) flags <= '0;
        else        flags <= flags_next;
    end
`endif

endmodule

// File: tb/tb_arithmetic_logical_unit.sv
// Self-checking bench for arithmetic_logical_unit: directed table plus random ops against an integer model.
module tb_arithmetic_logical_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] operand_1 = '0;
    logic [7:0] operand_2 = '0;
    logic [3:0] operator = '0;
    logic [7:0] Answer1;
    logic [7:0] Answer2;
`ifdef ALU_FLAGS_EN
    logic [3:0] flags;
    logic [3:0] flag_q[$];
`endif

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];

    arithmetic_logical_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .operator  (operator),
`ifdef ALU_FLAGS_EN
        .flags     (flags),
`endif
        .Answer1   (Answer1),
        .Answer2   (Answer2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode rules.
    function automatic logic [15:0] model_answers(int a, int b, int op);
        int r1, r2, p, s;
        r1 = 0; r2 = 0;
        case (op)
            0: begin r1 = (a + b) % 256; r2 = (a + b) / 256; end
            1: begin r1 = (a - b + 256) % 256; r2 = (a < b) ? 1 : 0; end
            2: begin p = a * b; r1 = p % 256; r2 = p / 256; end
            3: begin r1 = a & b; r2 = a | b; end
            4: begin r1 = a ^ b; r2 = 255 - (a ^ b); end
            5: begin s = b % 8; r1 = (a * (1 << s)) % 256; r2 = a / (1 << s); end
            6: begin
                if (b == 0) begin r1 = 255; r2 = a; end
                else begin r1 = a / b; r2 = a % b; end
            end
            default: begin r1 = 0; r2 = 0; end
        endcase
        return {8'(r1), 8'(r2)};
    endfunction

`ifdef ALU_FLAGS_EN
    function automatic logic [3:0] model_flags(int a, int b, int op);
        logic [15:0] ans;
        int sa, sb, sr;
        logic z, c, v, d;
        ans = model_answers(a, b, op);
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        z = (ans[15:8] == 8'd0);
        c = 1'b0; v = 1'b0;
        d = (op == 6) && (b == 0);
        if (op == 0) begin c = (a + b) > 255; sr = sa + sb; v = (sr > 127) || (sr < -128); end
        if (op == 1) begin c = a < b; sr = sa - sb; v = (sr > 127) || (sr < -128); end
        if (op == 2) c = (a * b) > 255;
        return {d, v, c, z};
    endfunction
`endif

    task automatic run_op(input string tag, input int a, input int b, input int op);
        logic [15:0] e;
        @(negedge clk);
        operand_1 = 8'(a);
        operand_2 = 8'(b);
        operator  = 4'(op);
        exp_q.push_back(model_answers(a, b, op));
`ifdef ALU_FLAGS_EN
        flag_q.push_back(model_flags(a, b, op));
`endif
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, {Answer1, Answer2}, e);
`ifdef ALU_FLAGS_EN
        check({tag, "_flags"}, {12'd0, flags}, {12'd0, flag_q.pop_front()});
`endif
    endtask

    task automatic apply_reset(input int edges);
        @(negedge clk);
        rst_n = 1'b0;
        operand_1 = 8'd6;
        operand_2 = 8'd5;
        operator  = 4'd0;
        repeat (edges) @(posedge clk);
        #1;
        check("reset", {Answer1, Answer2}, 16'h0000);
`ifdef ALU_FLAGS_EN
        check("reset_flags", {12'd0, flags}, 16'h0000);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int a, b, op;
        apply_reset(2);

        run_op("add_6_5", 6, 5, 0);
        run_op("add_16_51", 16, 51, 0);
        run_op("add_carry", 200, 100, 0);
        run_op("sub_6_5", 6, 5, 1);
        run_op("sub_20_8", 20, 8, 1);
        run_op("sub_borrow", 5, 6, 1);
        run_op("mul_6_5", 6, 5, 2);
        run_op("mul_23_55", 23, 55, 2);
        run_op("logic1", 56, 90, 3);
        run_op("logic2", 8, 5, 4);
        run_op("shift", 2, 1, 5);
        run_op("shift_hi_b", 129, 255, 5);
        run_op("reserved9", 77, 33, 9);
        run_op("reserved15", 255, 255, 15);
        run_op("div_6_5", 6, 5, 6);
        run_op("div_by_zero", 5, 0, 6);
        run_op("div_0_by_0", 0, 0, 6);
        run_op("div_255_1", 255, 1, 6);
        run_op("add_ovf", 127, 1, 0);
        run_op("sub_ovf", 128, 1, 1);

        // Reset mid-run must override live inputs.
        run_op("pre_reset", 250, 250, 2);
        apply_reset(1);

        for (int i = 0; i < 400; i++) begin
            a  = $urandom_range(0, 255);
            b  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 255);
            op = ($urandom_range(0, 7) == 0) ? $urandom_range(7, 15) : $urandom_range(0, 6);
            run_op("rand", a, b, op);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
